// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface nibble_serial_adder_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit ripple-carry slice, one nibble per clock, LSB nibble first.
// The slice carry is registered between cycles; the result is published only when complete.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);
  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            carry;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    work;
  logic [W-1:0]    work_nxt;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;

  logic [4:0]      chain;
  logic [3:0]      slice_sum;
  logic            slice_cout;

  // The single 4-bit ripple-carry slice; operands are shifted so the active nibble sits at [3:0].
  always_comb begin
    chain     = '0;
    slice_sum = '0;
    chain[0]  = carry;
    for (int i = 0; i < 4; i++) begin
      slice_sum[i] = op_a[i] ^ op_b[i] ^ chain[i];
      chain[i+1]   = (op_a[i] & op_b[i]) | (chain[i] & (op_a[i] ^ op_b[i]));
    end
    slice_cout = chain[4];
  end

  // Working register with the current slice result merged into nibble idx.
  always_comb begin
    work_nxt = work;
    for (int n = 0; n < int'(NIBBLES); n++) begin
      if (idx == IDXW'(n)) work_nxt[4*n +: 4] = slice_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      work   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          work  <= work_nxt;
          carry <= slice_cout;
          op_a  <= op_a >> 4;
          op_b  <= op_b >> 4;
          idx   <= idx + IDXW'(1);
          if (idx == LAST) begin
            // op_a[3]/op_b[3] hold the original sign bits on the final nibble.
            state  <= DONE;
            idx    <= '0;
            sum_q  <= work_nxt;
            cout_q <= slice_cout;
            ovf_q  <= op_a[3] ^ op_b[3] ^ slice_sum[3] ^ slice_cout;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: cycle-level arithmetic model compared every cycle,
// plus directed literal cases, backpressure, mid-add reset, back-to-back and random traffic.
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(N)) bus();
  nibble_serial_adder #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: m_cnt 0 = idle, 1..N = adding, N+1 = result presented.
  int           m_cnt = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_sum;
  logic         p_cout;
  logic         p_ovf;
  int           cyc = 0;
  int           d_emit = 0;
  int           acc_cyc[$];

  // Returns {overflow, cout, sum} from plain unsigned and signed arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    logic [W:0] u;
    longint     s;
    longint     lim;
    logic       o;
    u   = (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
    s   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    lim = longint'(1) <<< (W - 1);
    o   = (s > lim - 1) || (s < -lim);
    return {o, u};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [W+1:0] r;
    cyc++;
    if (rst) begin
      m_cnt  = 0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_cnt == 0) begin
      if (bus.in_valid) begin
        r = ref_add(bus.a, bus.b, bus.cin);
        {p_ovf, p_cout, p_sum} = r;
        m_cnt = 1;
        acc_cyc.push_back(cyc);
      end
    end else if (m_cnt <= N) begin
      m_cnt++;
      if (m_cnt == N + 1) begin
        m_sum  = p_sum;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
    end else if (bus.out_ready) begin
      m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  64'(bus.in_ready),  64'(m_cnt == 0 && !rst));
      chk("out_valid", 64'(bus.out_valid), 64'(m_cnt == N + 1));
      chk("sum",       64'(bus.sum),       64'(m_sum));
      chk("cout",      64'(bus.cout),      64'(m_cout));
      chk("overflow",  64'(bus.overflow),  64'(m_ovf));
      if (bus.out_valid && bus.out_ready) d_emit++;
    end
  end

  // Present one operand set, wait for the result and compare with literal expectations.
  task automatic run_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
    int g;
    int lat;
    int ir_hi;
    bus.a = x; bus.b = y; bus.cin = c; bus.in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk({nm, "_accept"}, 64'(g < 50), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1; ir_hi = 0;
    while (!bus.out_valid && lat < 50) begin
      if (bus.in_ready) ir_hi++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"},  64'(lat),          64'(N + 1));
    chk({nm, "_busy_rdy"}, 64'(ir_hi),        64'(0));
    chk({nm, "_sum"},      64'(bus.sum),      64'(es));
    chk({nm, "_cout"},     64'(bus.cout),     64'(ec));
    chk({nm, "_ovf"},      64'(bus.overflow), 64'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    int s0, e0, k, g, vcnt;
    logic ir;
    logic [W-1:0] held;

    rst = 1'b1; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;

    chk("ref_pin_plain", 64'(ref_add(16'h1234, 16'h4321, 1'b0)), 64'(18'h05555));
    chk("ref_pin_ovf",   64'(ref_add(16'h7FFF, 16'h0001, 1'b0)), 64'(18'h28000));
    chk("ref_pin_both",  64'(ref_add(16'h8000, 16'h8000, 1'b1)), 64'(18'h30001));

    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_sum",       64'(bus.sum),       64'(0));
    @(posedge clk); #1;

    run_op("plain",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("negovf", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);

    // Backpressure with competing operands offered while the result is held.
    bus.out_ready = 1'b0;
    run_op("bp", 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0);
    s0 = acc_cyc.size();
    held = bus.sum;
    bus.a = 16'h0F0F; bus.b = 16'h0101; bus.cin = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_hold",  64'(bus.sum),       64'(held));
      chk("bp_rdy",   64'(bus.in_ready),  64'(0));
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_idle",     64'(bus.in_ready),     64'(1));
    chk("bp_nocap",    64'(acc_cyc.size()),   64'(s0));

    // Reset two nibbles into an add.
    bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_sum",   64'(bus.sum),       64'(0));
    chk("mid_rst_cout",  64'(bus.cout),      64'(0));
    chk("mid_rst_rdy",   64'(bus.in_ready),  64'(1));
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) vcnt++;
    end
    chk("mid_rst_noemit", 64'(vcnt), 64'(0));
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    s0 = acc_cyc.size(); e0 = d_emit; k = 0; g = 0;
    bus.out_ready = 1'b1;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom); bus.in_valid = 1'b1;
    while (k < 3 && g < 100) begin
      @(negedge clk);
      ir = bus.in_ready;
      @(posedge clk); #1;
      g++;
      if (ir) begin
        k++;
        if (k == 3) bus.in_valid = 1'b0;
        else begin
          bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        end
      end
    end
    repeat (8) begin @(posedge clk); #1; end
    chk("b2b_accepts", 64'(k), 64'(3));
    chk("b2b_gap1", 64'(acc_cyc.size() >= s0 + 3 ? acc_cyc[s0+1] - acc_cyc[s0] : -1), 64'(6));
    chk("b2b_gap2", 64'(acc_cyc.size() >= s0 + 3 ? acc_cyc[s0+2] - acc_cyc[s0+1] : -1), 64'(6));
    chk("b2b_emits", 64'(d_emit - e0), 64'(3));

    // Random traffic, random backpressure and occasional reset.
    repeat (600) begin
      @(posedge clk); #1;
      rst           = ($urandom_range(0, 99) == 0);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.cin       = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
